// File: rtl/ubw_pkg.sv
`default_nettype none
// ============================================================================
// Module : ubw_pkg
// Brief  : Shared FSM state encoding and status-line layout for update_bin_writer.
// Rev    : 1.0
// ============================================================================
package ubw_pkg;

    localparam int LINE_W = 512;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_STATUS = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } ubw_state_e;

    // Status line: magic word, overflow flag, then one 32-bit count per bin
    localparam int          STATUS_MAGIC_LSB = 0;
    localparam int          STATUS_MAGIC_W   = 64;
    localparam logic [63:0] STATUS_MAGIC     = 64'd1;
    localparam int          STATUS_OVF_BIT   = 64;
    localparam int          STATUS_CNT_LSB   = 128;
    localparam int          STATUS_CNT_W     = 32;
    localparam int          STATUS_MAX_BINS  = (LINE_W - STATUS_CNT_LSB) / STATUS_CNT_W;

endpackage
`default_nettype wire

// File: rtl/ubw_fifo.sv
`default_nettype none
// ============================================================================
// Module : ubw_fifo
// Brief  : Write buffer holding {line address, line data} entries, fall-through read.
// Rev    : 1.0
// ============================================================================
module ubw_fifo #(
    parameter int FIFO_DEPTH = 64,
    parameter int WIDTH      = 554,
    localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = push && (count_q != (PTR_W+1)'(FIFO_DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/update_bin_writer.sv
`default_nettype none
// ============================================================================
// Module : update_bin_writer
// Brief  : Streams update lines into per-bin regions, then writes a status line.
// Rev    : 1.0
// ============================================================================
module update_bin_writer
    import ubw_pkg::*;
#(
    parameter int NUM_BINS        = 4,
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 128,
    parameter int ADDR_W          = 42,
    localparam int BIN_W          = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_BINS*ADDR_W-1:0] bin_base,
    input  logic [31:0]                bin_limit,
    input  logic [ADDR_W-1:0]          status_addr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BIN_W-1:0]           in_bin,
    input  logic [LINE_W-1:0]          in_data,
    input  logic                       in_last,
    output logic                       wr_valid,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [LINE_W-1:0]          wr_data,
    input  logic                       tx_alm_full,
    input  logic                       wr_rsp_valid,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_BINS*32-1:0]     bin_count,
    output logic                       overflow
);

    localparam int ENTRY_W     = ADDR_W + LINE_W;
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int STATUS_BINS = (NUM_BINS < STATUS_MAX_BINS) ? NUM_BINS : STATUS_MAX_BINS;

    ubw_state_e          state_q, state_d;
    logic                last_seen_q, last_seen_d;
    logic [31:0]         req_cnt_q, req_cnt_d;
    logic [31:0]         rsp_cnt_q, rsp_cnt_d;
    logic [31:0]         bin_cnt_q [NUM_BINS];
    logic [31:0]         bin_cnt_d [NUM_BINS];
    logic                overflow_q, overflow_d;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [LINE_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  fifo_in;
    logic [ENTRY_W-1:0]  fifo_out;

    logic [ADDR_W-1:0]   sel_base;
    logic [31:0]         sel_cnt;
    logic                accept;
    logic                at_limit;
    logic [31:0]         outstanding;
    logic                can_issue;
    logic [LINE_W-1:0]   status_word;

    ubw_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        sel_base = '0;
        sel_cnt  = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (in_bin == BIN_W'(i)) begin
                sel_base = bin_base[i*ADDR_W +: ADDR_W];
                sel_cnt  = bin_cnt_q[i];
            end
        end
    end

    assign in_ready    = (state_q == ST_STREAM) && (fifo_count < CNT_W'(FIFO_DEPTH - 2));
    assign accept      = in_valid && in_ready;
    assign at_limit    = (sel_cnt == bin_limit);
    assign fifo_push   = accept && !at_limit;
    assign fifo_in     = {sel_base + ADDR_W'(sel_cnt), in_data};
    assign outstanding = req_cnt_q - rsp_cnt_q;
    assign can_issue   = !tx_alm_full && (outstanding < 32'(MAX_OUTSTANDING));
    assign fifo_pop    = (state_q == ST_STREAM) && !fifo_empty && can_issue;

    always_comb begin
        status_word = '0;
        status_word[STATUS_MAGIC_LSB +: STATUS_MAGIC_W] = STATUS_MAGIC;
        status_word[STATUS_OVF_BIT] = overflow_q;
        for (int i = 0; i < STATUS_BINS; i++) begin
            status_word[STATUS_CNT_LSB + STATUS_CNT_W*i +: STATUS_CNT_W] = bin_cnt_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        last_seen_d = last_seen_q;
        req_cnt_d   = req_cnt_q;
        // Responses outside a pass belong to an abandoned one and are dropped
        rsp_cnt_d   = rsp_cnt_q + 32'(wr_rsp_valid && (state_q != ST_IDLE));
        bin_cnt_d   = bin_cnt_q;
        overflow_d  = overflow_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_STREAM;
                    last_seen_d = 1'b0;
                    req_cnt_d   = '0;
                    rsp_cnt_d   = '0;
                    overflow_d  = 1'b0;
                    for (int i = 0; i < NUM_BINS; i++) begin
                        bin_cnt_d[i] = '0;
                    end
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    if (at_limit) begin
                        overflow_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_BINS; i++) begin
                            if (in_bin == BIN_W'(i)) begin
                                bin_cnt_d[i] = bin_cnt_q[i] + 32'd1;
                            end
                        end
                    end
                end
                if (in_last) begin
                    last_seen_d = 1'b1;
                end
                if (fifo_pop) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = fifo_out[ENTRY_W-1 -: ADDR_W];
                    wr_data_d  = fifo_out[LINE_W-1:0];
                end
                // A word pushed this cycle still has to drain before the status line
                if (last_seen_q && fifo_empty && !fifo_push) begin
                    state_d = ST_STATUS;
                end
            end
            ST_STATUS: begin
                if (can_issue) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = status_addr;
                    wr_data_d  = status_word;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (req_cnt_q == rsp_cnt_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_valid_d) begin
            req_cnt_d = req_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_seen_q <= 1'b0;
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) begin
                bin_cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            last_seen_q <= last_seen_d;
            req_cnt_q   <= req_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            overflow_q  <= overflow_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            for (int i = 0; i < NUM_BINS; i++) begin
                bin_cnt_q[i] <= bin_cnt_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin_out
            assign bin_count[g*32 +: 32] = bin_cnt_q[g];
        end
    endgenerate

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire
